ct_had_sync_req_tx: RTL

- Source-side transmitter for the 3-flop pulse synchronizer, which detects rising edges.
- Converts single-cycle request events in the local domain into held levels on sync_req, which drives the remote synchronizer's sync_in.
- Holds sync_req high until the remote side acknowledges, then holds it low for a guaranteed minimum so every rising edge is seen.
- Queues requests that arrive while a transfer is in flight; flags overflow and ack timeout.

---
 rtl/ct_had_sync_req_tx_if.sv | 25 ++
 rtl/ct_had_sync_req_tx.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ct_had_sync_req_tx_if.sv
// Handshake bundle between the request source and the sync-request transmitter.
interface ct_had_sync_req_tx_if #(
  parameter int unsigned CNT_W = 3
);
  logic             req_vld;
  logic             ack_pulse;
  logic             err_clr;
  logic             sync_req;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             ovf_err;
  logic             timeout_err;

  // Request source / status observer side.
  modport master (
    output req_vld, ack_pulse, err_clr,
    input  sync_req, busy, pend_cnt, ovf_err, timeout_err
  );

  // Transmitter side.
  modport slave (
    input  req_vld, ack_pulse, err_clr,
    output sync_req, busy, pend_cnt, ovf_err, timeout_err
  );
endinterface

// File: rtl/ct_had_sync_req_tx.sv
// Source-side transmitter for a rising-edge pulse synchronizer. Turns one-cycle
// request events into held levels on sync_req, waits for the echoed ack, then
// holds sync_req low long enough that every rising edge is seen remotely.
// Requests arriving mid-transfer are counted and launched in turn.
module ct_had_sync_req_tx #(
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned LOW_CYC = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  ct_had_sync_req_tx_if.slave bus
);

  localparam int unsigned      LOW_W    = (LOW_CYC > 1) ? $clog2(LOW_CYC) : 1;
  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [LOW_W-1:0] LOW_LOAD = LOW_W'(LOW_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q;
  logic             sync_req_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [LOW_W-1:0] low_cnt_q;
  logic [CNT_W-1:0] pend_cnt_q;
  logic             ovf_err_q;
  logic             timeout_err_q;

  logic launch;
  logic ack_hit;
  logic to_hit;
  logic ovf_set;

  // Decode this cycle's launch, ack, timeout and drop events.
  always_comb begin
    launch  = (state_q == StIdle) && ((pend_cnt_q != '0) || bus.req_vld);
    ack_hit = (state_q == StHigh) && bus.ack_pulse;
    // Ack in the final HIGH cycle takes priority over the timeout.
    to_hit  = (state_q == StHigh) && !bus.ack_pulse && (to_cnt_q == TO_LAST);
    ovf_set = bus.req_vld && !launch && (pend_cnt_q == PEND_MAX);
  end

  // Transfer FSM with registered sync_req and the HIGH/LOW duration counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_req_q <= 1'b0;
      to_cnt_q   <= '0;
      low_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            state_q    <= StHigh;
            sync_req_q <= 1'b1;
            to_cnt_q   <= '0;
          end
        end
        StHigh: begin
          if (ack_hit || to_hit) begin
            state_q    <= StLow;
            sync_req_q <= 1'b0;
            low_cnt_q  <= LOW_LOAD;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        StLow: begin
          if (low_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            low_cnt_q <= low_cnt_q - LOW_W'(1);
          end
        end
        default: begin
          state_q    <= StIdle;
          sync_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Pending-request counter: queue on arrival, drain on launch, saturate when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt_q <= '0;
    end else if (bus.req_vld && !launch) begin
      if (pend_cnt_q != PEND_MAX) begin
        pend_cnt_q <= pend_cnt_q + CNT_W'(1);
      end
    end else if (launch && !bus.req_vld && (pend_cnt_q != '0)) begin
      pend_cnt_q <= pend_cnt_q - CNT_W'(1);
    end
  end

  // Sticky error flags; a new event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        ovf_err_q <= 1'b0;
      end
      if (to_hit) begin
        timeout_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        timeout_err_q <= 1'b0;
      end
    end
  end

  assign bus.sync_req    = sync_req_q;
  assign bus.pend_cnt    = pend_cnt_q;
  assign bus.ovf_err     = ovf_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = (state_q != StIdle) || (pend_cnt_q != '0);

endmodule
